hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall controller for the five-stage CPU. It compares the source registers of the instruction in D against the destinations in E and M using Tuse/Tnew timing, and tracks the multiply/divide unit's busy period. From these it drives the enable of the PC and of the F/D pipeline register, and the flush of the D/E register. The block sits beside the F/D and D/E registers and is their only source of `en` and clear.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu in cycles
- `DIV_CYCLES`, 10, busy duration of div/divu in cycles

Ports:
- `clk` in 1, rising-edge clock
- `reset_n` in 1, asynchronous, active-low reset
- `D_rs`, `D_rt` in 5, source register numbers of the D instruction
- `D_Tuse_rs`, `D_Tuse_rt` in 2, cycles until the operand is needed; 3 = operand unused
- `D_md_use` in 1, D instruction is mult/div/mfhi/mflo/mthi/mtlo
- `E_A3`, `M_A3` in 5, destination register of the E/M instruction; 0 = none
- `E_Tnew`, `M_Tnew` in 2, cycles until the E/M result is available
- `E_md_start` in 1, E instruction is mult/multu/div/divu
- `E_md_op` in 1, 0 = mult family, 1 = div family; qualified by `E_md_start`
- `F_PC_en` out 1, PC write enable
- `FD_en` out 1, F/D register enable
- `DE_clr` out 1, D/E register clear (bubble insert)
- `stall` out 1, overall stall indicator
- `md_busy` out 1, mult/div unit computing
- `md_done` out 1, one-cycle pulse when a mult/div result becomes valid

## Operation
Register-hazard stall (combinational):
- `stall_rs_E` = (D_rs != 0) && (D_rs == E_A3) && (E_Tnew > D_Tuse_rs)
- `stall_rs_M` = (D_rs != 0) && (D_rs == M_A3) && (M_Tnew > D_Tuse_rs)
- `rt` terms are the same with `D_rt` / `D_Tuse_rt`.
- Tuse = 3 never stalls, because Tnew ≤ 2.

Mult/div stall:
- `stall_md` = D_md_use && (md_busy || E_md_start)

Stall outputs:
- `stall` = OR of all stall terms
- `F_PC_en` = `FD_en` = !stall
- `DE_clr` = stall

Busy counter:
- Holds a 4-bit remaining-cycle count `cnt`.
- On an edge with `E_md_start` && `cnt` == 0, `cnt` loads `MULT_CYCLES` or `DIV_CYCLES` according to `E_md_op`.
- Otherwise, if `cnt` != 0, `cnt` decrements by 1.
- `md_busy` = (`cnt` != 0).
- `md_done` is registered: it takes the value (`cnt` == 1) at each edge.
- `E_md_start` while `cnt` != 0 is ignored; there is no reload. This case cannot occur legally, because `stall_md` holds md instructions in D.

The counter runs independently of `stall`; stalls never freeze it.

## Timing
- Stall outputs have zero latency: they are combinational from the inputs in the same cycle.
- Reset (`reset_n` = 0, asynchronous):
  - `cnt` = 0, `md_busy` = 0, `md_done` = 0.
  - Stall outputs then follow the inputs only.
- Mult/div start sampled at edge t:
  - `md_busy` is high in cycles t+1 … t+N.
  - `md_done` is high in cycle t+N+1 only, which is the same cycle `md_busy` first reads 0.
- A dependent mfhi/mflo in D during start cycle t stalls in cycles t … t+N and advances at the edge ending cycle t+N.
- Simultaneous register and md stalls produce a single stall; there is no double-counting.
- Reset mid-count aborts immediately: `md_done` is not pulsed.
- `N` must satisfy 1 ≤ N ≤ 15; parameter values outside this range are illegal.

## Structure
- Shared package `cpu_pkg` holds:
  - `TUSE_NONE` = 2'd3
  - `MD_MULT` = 1'b0, `MD_DIV` = 1'b1
  - default cycle constants `MULT_CYCLES_DEF` = 5, `DIV_CYCLES_DEF` = 10
- Sub-module `md_busy_counter`: the counter, `md_busy` and `md_done` logic, with the cycle parameters passed down.
- Top level: combinational hazard compare plus the counter instance.

## Test plan
- Load-use: D_rs = 5, D_Tuse_rs = 0; E_A3 = 5, E_Tnew = 2 → stall = 1, FD_en = 0, F_PC_en = 0, DE_clr = 1. Next cycle E_A3 = 0, M_A3 = 5, M_Tnew = 1 → stall = 1. Following cycle M_Tnew = 0 → stall = 0.
- Register $0 and unused operand:
  - D_rs = 0 = E_A3, E_Tnew = 2, D_Tuse_rs = 0 → stall = 0.
  - D_rt = 7 = E_A3, D_Tuse_rt = 3 → stall = 0.
- Mult: E_md_start = 1, E_md_op = 0 at edge t → md_busy high for 5 cycles; md_done high in cycle t+6 only. A mflo held in D has stall = 1 through cycle t+5, then 0.
- Div: E_md_op = 1 → md_busy high for 10 cycles. A second E_md_start pulse injected at t+3 is ignored, so busy still ends at t+10.
- Reset mid-operation: reset_n pulled low at t+4 of a div → md_busy = 0 and md_done = 0 immediately, with no done pulse after release.
- Combined: register stall and md stall active together → a single bubble per cycle. DE_clr stays high exactly as long as either stall term is true.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for hazard and mult/div control
package cpu_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy countdown with registered done pulse
module md_busy_counter
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic md_start,
  input  logic md_op,
  output logic md_busy,
  output logic md_done
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  // A start while already counting is dropped; the D-stage md stall makes it unreachable.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start && (cnt_q == 4'd0)) begin
      cnt_d = (md_op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    done_d = (cnt_q == 4'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign md_busy = (cnt_q != 4'd0);
  assign md_done = done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - Tuse/Tnew hazard compare and mult/div stall for the F/D and D/E registers
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_md_use,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  logic [1:0] E_Tnew,
  input  logic [1:0] M_Tnew,
  input  logic       E_md_start,
  input  logic       E_md_op,
  output logic       F_PC_en,
  output logic       FD_en,
  output logic       DE_clr,
  output logic       stall,
  output logic       md_busy,
  output logic       md_done
);

  logic rs_live, rt_live;
  logic stall_rs_E, stall_rs_M, stall_rt_E, stall_rt_M, stall_md;
  logic stall_d;

  // Tnew never exceeds 2, so an unused operand cannot stall; the guard just makes that explicit.
  assign rs_live = (D_rs != 5'd0) && (D_Tuse_rs != TUSE_NONE);
  assign rt_live = (D_rt != 5'd0) && (D_Tuse_rt != TUSE_NONE);

  always_comb begin
    stall_rs_E = rs_live && (D_rs == E_A3) && (E_Tnew > D_Tuse_rs);
    stall_rs_M = rs_live && (D_rs == M_A3) && (M_Tnew > D_Tuse_rs);
    stall_rt_E = rt_live && (D_rt == E_A3) && (E_Tnew > D_Tuse_rt);
    stall_rt_M = rt_live && (D_rt == M_A3) && (M_Tnew > D_Tuse_rt);
    stall_md   = D_md_use && (md_busy || E_md_start);
    stall_d    = stall_rs_E || stall_rs_M || stall_rt_E || stall_rt_M || stall_md;
  end

  assign stall   = stall_d;
  assign F_PC_en = !stall_d;
  assign FD_en   = !stall_d;
  assign DE_clr  = stall_d;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_start (E_md_start),
    .md_op    (E_md_op),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_md_use, E_md_start, E_md_op;
  logic       F_PC_en, FD_en, DE_clr, stall, md_busy, md_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycle index, cycle of the accepted start, its length, and the done cycle.
  int mdl_cyc   = 0;
  int mdl_start = -1000;
  int mdl_len   = 0;
  int mdl_done  = -1000;

  hazard_stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_md_use   (D_md_use),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .E_md_start (E_md_start),
    .E_md_op    (E_md_op),
    .F_PC_en    (F_PC_en),
    .FD_en      (FD_en),
    .DE_clr     (DE_clr),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_done    (md_done)
  );

  always #5 clk = ~clk;

  function automatic logic model_busy();
    return (mdl_cyc > mdl_start) && (mdl_cyc <= mdl_start + mdl_len);
  endfunction

  function automatic logic model_done();
    return mdl_cyc == mdl_done;
  endfunction

  function automatic logic model_stall();
    int src [2];
    int tuse [2];
    logic s;
    src[0] = int'(D_rs);  tuse[0] = int'(D_Tuse_rs);
    src[1] = int'(D_rt);  tuse[1] = int'(D_Tuse_rt);
    s = D_md_use && (model_busy() || E_md_start);
    for (int i = 0; i < 2; i++) begin
      if (src[i] != 0) begin
        if (src[i] == int'(E_A3) && int'(E_Tnew) > tuse[i]) s = 1'b1;
        if (src[i] == int'(M_A3) && int'(M_Tnew) > tuse[i]) s = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_md_use = 0;
    E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0; E_md_start = 0; E_md_op = 0;
  endtask

  // Advance one clock: model absorbs the start seen at this edge, then inputs may change.
  task automatic tick();
    if (E_md_start && !model_busy()) begin
      mdl_start = mdl_cyc;
      mdl_len   = E_md_op ? DIV_N : MULT_N;
      mdl_done  = mdl_cyc + mdl_len + 1;
    end
    @(posedge clk);
    mdl_cyc++;
    #1;
  endtask

  task automatic model_reset();
    mdl_start = -1000;
    mdl_done  = -1000;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #1;
    model_reset();
    repeat (2) tick();
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_md: busy=%b done=%b want 0 0", md_busy, md_done);
    end
    checks++;
    if (stall !== 1'b0 || FD_en !== 1'b1 || F_PC_en !== 1'b1 || DE_clr !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: stall=%b fd=%b pc=%b clr=%b want 0 1 1 0", stall, FD_en, F_PC_en, DE_clr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    D_rs = 5; D_Tuse_rs = 0; E_A3 = 5; E_Tnew = 2;
    #1;
    checks++;
    if (stall !== 1'b1 || FD_en !== 1'b0 || F_PC_en !== 1'b0 || DE_clr !== 1'b1) begin
      failures++;
      $display("FAIL load_use_E: stall=%b fd=%b pc=%b clr=%b want 1 0 0 1", stall, FD_en, F_PC_en, DE_clr);
    end
    tick();
    E_A3 = 0; M_A3 = 5; M_Tnew = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_M: stall=%b want 1", stall);
    end
    tick();
    M_Tnew = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || FD_en !== 1'b1) begin
      failures++;
      $display("FAIL load_use_ready: stall=%b fd=%b want 0 1", stall, FD_en);
    end
    tick();
  endtask

  task automatic test_zero_unused();
    clear_inputs();
    D_rs = 0; E_A3 = 0; E_Tnew = 2; D_Tuse_rs = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reg_zero: stall=%b want 0", stall);
    end
    D_rs = 0; D_rt = 7; E_A3 = 7; D_Tuse_rt = 3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL unused_rt: stall=%b want 0", stall);
    end
    D_Tuse_rt = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL used_rt: stall=%b want 1", stall);
    end
    tick();
  endtask

  task automatic test_mult();
    int busy_cycles;
    int done_off;
    clear_inputs();
    D_md_use = 1; E_md_start = 1; E_md_op = 0;
    busy_cycles = 0;
    done_off = -1;
    for (int k = 0; k <= MULT_N + 2; k++) begin
      #1;
      checks++;
      if (stall !== (k <= MULT_N)) begin
        failures++;
        $display("FAIL mult_stall cyc+%0d: stall=%b want %b", k, stall, (k <= MULT_N));
      end
      if (md_busy === 1'b1) busy_cycles++;
      if (md_done === 1'b1) done_off = k;
      tick();
      E_md_start = 0;
    end
    checks++;
    if (busy_cycles != MULT_N || done_off != MULT_N + 1) begin
      failures++;
      $display("FAIL mult_timing: busy=%0d done_at=%0d want %0d %0d", busy_cycles, done_off, MULT_N, MULT_N + 1);
    end
  endtask

  task automatic test_div_reload();
    int last_busy;
    clear_inputs();
    E_md_start = 1; E_md_op = 1;
    last_busy = -1;
    for (int k = 0; k <= DIV_N + 3; k++) begin
      #1;
      checks++;
      if (md_busy !== model_busy() || md_done !== model_done()) begin
        failures++;
        $display("FAIL div_md cyc+%0d: busy=%b done=%b want %b %b", k, md_busy, md_done, model_busy(), model_done());
      end
      if (md_busy === 1'b1) last_busy = k;
      tick();
      E_md_start = (k == 2);
      E_md_op = 1'b0;
    end
    checks++;
    if (last_busy != DIV_N) begin
      failures++;
      $display("FAIL div_no_reload: last_busy=+%0d want +%0d", last_busy, DIV_N);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    clear_inputs();
    E_md_start = 1; E_md_op = 1;
    tick();
    E_md_start = 0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b want 0 0", md_busy, md_done);
    end
    tick();
    reset_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < DIV_N + 2; k++) begin
      #1;
      if (md_done === 1'b1 || md_busy === 1'b1) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_mid_after: active_cycles=%0d want 0", done_seen);
    end
  endtask

  task automatic test_combined();
    clear_inputs();
    E_md_start = 1; E_md_op = 0;
    tick();
    E_md_start = 0;
    D_md_use = 1; D_rs = 9; D_Tuse_rs = 0; E_A3 = 9; E_Tnew = 1;
    #1;
    checks++;
    if (stall !== 1'b1 || DE_clr !== 1'b1 || FD_en !== 1'b0) begin
      failures++;
      $display("FAIL combined_both: stall=%b clr=%b fd=%b want 1 1 0", stall, DE_clr, FD_en);
    end
    tick();
    E_A3 = 0;
    for (int k = 0; k < MULT_N + 1; k++) begin
      #1;
      checks++;
      if (DE_clr !== model_stall() || stall !== DE_clr || FD_en !== !DE_clr) begin
        failures++;
        $display("FAIL combined_md cyc%0d: clr=%b stall=%b fd=%b want clr %b", k, DE_clr, stall, FD_en, model_stall());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic exp_s;
    for (int k = 0; k < 400; k++) begin
      D_rs = 5'($urandom_range(0, 3));
      D_rt = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3));
      M_A3 = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom_range(0, 3));
      D_Tuse_rt = 2'($urandom_range(0, 3));
      E_Tnew = 2'($urandom_range(0, 2));
      M_Tnew = 2'($urandom_range(0, 2));
      D_md_use = ($urandom_range(0, 3) == 0);
      E_md_start = ($urandom_range(0, 9) == 0);
      E_md_op = 1'($urandom_range(0, 1));
      #1;
      exp_s = model_stall();
      checks++;
      if (stall !== exp_s || DE_clr !== exp_s || FD_en !== !exp_s || F_PC_en !== !exp_s ||
          md_busy !== model_busy() || md_done !== model_done()) begin
        failures++;
        $display("FAIL random cyc%0d: stall=%b busy=%b done=%b want %b %b %b",
                 k, stall, md_busy, md_done, exp_s, model_busy(), model_done());
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_zero_unused();
    repeat (2) tick();
    test_mult();
    test_div_reload();
    test_reset_mid();
    test_combined();
    clear_inputs();
    repeat (MULT_N + 2) tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
